// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA round controller.
// Holds the controller state encoding and the standard round/word counts.
package sha_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ACC,
        DONE
    } sha_ctrl_state_t;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA1_ROUNDS   = 80;
    localparam int SHA512_ROUNDS = 80;
    localparam int SHA_MSG_WORDS = 16;

endpackage

// File: rtl/sha_round_cnt.sv
// Round counter for the SHA controller: counts 0..ROUNDS-1 while enabled and
// wraps to 0 after the terminal round, so it idles at 0 between blocks.
module sha_round_cnt #(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] idx,
    output logic             last
);

    assign last = (idx == CNT_W'(ROUNDS - 1));

    // Round index register; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value, independent of statement order.
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (en) begin
            idx <= last ? '0 : idx + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA round controller: sequences multi-block messages through ROUNDS
// compression rounds and drives the datapath strobes.
// Optional feature: define SHA_CTRL_ABORT_EN to add the i_abort port, which
// returns the controller to IDLE from any state with highest priority.
module sha_round_ctrl
    import sha_ctrl_pkg::*;
#(
    parameter int       ROUNDS    = SHA256_ROUNDS,
    parameter int       MSG_WORDS = SHA_MSG_WORDS,
    parameter int       BLK_CNT_W = 16,
    localparam int      CNT_W     = $clog2(ROUNDS)
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset_n,
`ifdef SHA_CTRL_ABORT_EN
    input  logic                 i_abort,
`endif
    input  logic                 i_start,
    input  logic                 i_blk_valid,
    input  logic                 i_last_blk,
    output logic                 o_blk_ready,
    output logic                 o_load_blk,
    output logic                 o_init,
    output logic                 o_round_en,
    output logic [CNT_W-1:0]     o_round_idx,
    output logic                 o_w_sel,
    output logic                 o_acc_en,
    output logic [BLK_CNT_W-1:0] o_blk_cnt,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready
);

    sha_ctrl_state_t state;
    logic            first_blk;
    logic            last_blk;
    logic            handshake;
    logic            cnt_last;
    logic            abort;

`ifdef SHA_CTRL_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Block handshake is Mealy on i_blk_valid so the block loads in the same
    // cycle the buffer offers it; abort suppresses it.
    assign handshake  = (state == LOAD) && i_blk_valid && !abort;
    assign o_load_blk = handshake;
    assign o_init     = handshake && first_blk;

    sha_round_cnt #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_round_cnt (
        .clk   (usr_clk),
        .rst_n (usr_reset_n),
        .clear (handshake || abort),
        .en    (state == ROUND),
        .idx   (o_round_idx),
        .last  (cnt_last)
    );

    // Controller FSM; registered outputs are set for the state being entered.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state       <= IDLE;
            first_blk   <= 1'b0;
            last_blk    <= 1'b0;
            o_blk_ready <= 1'b0;
            o_round_en  <= 1'b0;
            o_w_sel     <= 1'b0;
            o_acc_en    <= 1'b0;
            o_blk_cnt   <= '0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            first_blk   <= 1'b0;
            last_blk    <= 1'b0;
            o_blk_ready <= 1'b0;
            o_round_en  <= 1'b0;
            o_w_sel     <= 1'b0;
            o_acc_en    <= 1'b0;
            o_blk_cnt   <= '0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            o_acc_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= LOAD;
                        first_blk   <= 1'b1;
                        o_blk_cnt   <= '0;
                        o_blk_ready <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (i_blk_valid) begin
                        state       <= ROUND;
                        last_blk    <= i_last_blk;
                        o_blk_ready <= 1'b0;
                        o_round_en  <= 1'b1;
                        // Round 0 always takes a message word (MSG_WORDS >= 1).
                        o_w_sel     <= 1'b0;
                        if (o_blk_cnt != {BLK_CNT_W{1'b1}}) begin
                            o_blk_cnt <= o_blk_cnt + BLK_CNT_W'(1);
                        end
                    end
                end
                ROUND: begin
                    if (cnt_last) begin
                        state      <= ACC;
                        o_round_en <= 1'b0;
                        o_w_sel    <= 1'b0;
                        o_acc_en   <= 1'b1;
                    end else begin
                        o_w_sel <= (int'(o_round_idx) + 1) >= MSG_WORDS;
                    end
                end
                ACC: begin
                    first_blk <= 1'b0;
                    if (last_blk) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end else begin
                        state       <= LOAD;
                        o_blk_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Self-checking bench for sha_round_ctrl: randomized multi-block messages,
// a queue-based scoreboard and a cycle monitor, plus an 80-round instance.
module tb_sha_round_ctrl;
    import sha_ctrl_pkg::*;

    localparam int R   = SHA256_ROUNDS;
    localparam int MW  = SHA_MSG_WORDS;
    localparam int BW  = 16;
    localparam int CW  = $clog2(R);
    localparam int R80 = SHA1_ROUNDS;

    logic usr_clk = 1'b0;
    logic usr_reset_n = 1'b1;
    logic i_start = 1'b0, i_blk_valid = 1'b0, i_last_blk = 1'b0;
    logic i_ready = 1'b0, i_abort = 1'b0;
    logic o_blk_ready, o_load_blk, o_init, o_round_en, o_w_sel, o_acc_en, o_busy, o_valid;
    logic [CW-1:0] o_round_idx;
    logic [BW-1:0] o_blk_cnt;

    logic s_start = 1'b0, s_valid = 1'b0, s_last = 1'b1, s_rdy = 1'b0, s_abort = 1'b0;
    logic p_ready, p_load, p_init, p_round_en, p_w_sel, p_acc_en, p_busy, p_valid;
    logic [$clog2(R80)-1:0] p_idx;
    logic [7:0] p_cnt;

    always #5 usr_clk = ~usr_clk;

    sha_round_ctrl #(.ROUNDS(R), .MSG_WORDS(MW), .BLK_CNT_W(BW)) dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
`ifdef SHA_CTRL_ABORT_EN
        .i_abort     (i_abort),
`endif
        .i_start     (i_start),
        .i_blk_valid (i_blk_valid),
        .i_last_blk  (i_last_blk),
        .o_blk_ready (o_blk_ready),
        .o_load_blk  (o_load_blk),
        .o_init      (o_init),
        .o_round_en  (o_round_en),
        .o_round_idx (o_round_idx),
        .o_w_sel     (o_w_sel),
        .o_acc_en    (o_acc_en),
        .o_blk_cnt   (o_blk_cnt),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    sha_round_ctrl #(.ROUNDS(R80), .MSG_WORDS(MW), .BLK_CNT_W(8)) dut80 (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
`ifdef SHA_CTRL_ABORT_EN
        .i_abort     (s_abort),
`endif
        .i_start     (s_start),
        .i_blk_valid (s_valid),
        .i_last_blk  (s_last),
        .o_blk_ready (p_ready),
        .o_load_blk  (p_load),
        .o_init      (p_init),
        .o_round_en  (p_round_en),
        .o_round_idx (p_idx),
        .o_w_sel     (p_w_sel),
        .o_acc_en    (p_acc_en),
        .o_blk_cnt   (p_cnt),
        .o_busy      (p_busy),
        .o_valid     (p_valid),
        .i_ready     (s_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no matching event expected one at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    // Scoreboard: expected blocks and expected per-message block counts.
    typedef struct {
        bit first;
        bit last;
        int num;
    } blk_exp_t;

    blk_exp_t blk_q[$];
    int       msg_q[$];

    typedef enum {M_IDLE, M_LOAD, M_ROUND, M_ACC, M_DONE} mon_phase_t;

    // Monitor: follows the protocol the spec describes, one step per cycle.
    initial begin : monitor
        mon_phase_t ph;
        blk_exp_t   cur;
        int         r;
        ph  = M_IDLE;
        r   = 0;
        cur = '{first: 1'b0, last: 1'b0, num: 0};
        forever begin
            @(negedge usr_clk);
            if (!usr_reset_n || i_abort) begin
                ph = M_IDLE;
                continue;
            end
            case (ph)
                M_IDLE: begin
                    check("idle_quiet", {o_busy, o_blk_ready, o_round_en, o_acc_en, o_valid, o_load_blk}, 0);
                    check("idle_idx", {o_w_sel, o_round_idx}, 0);
                    if (i_start) ph = M_LOAD;
                end
                M_LOAD: begin
                    check("load_ctl", {o_blk_ready, o_busy, o_round_en, o_acc_en, o_valid}, 5'b11000);
                    check("load_mealy", o_load_blk, i_blk_valid);
                    if (i_blk_valid) begin
                        if (blk_q.size() == 0) begin
                            fail_now("unexpected_block");
                        end else begin
                            cur = blk_q.pop_front();
                            check("init", o_init, cur.first);
                        end
                        r  = 0;
                        ph = M_ROUND;
                    end else begin
                        check("no_init", o_init, 0);
                    end
                end
                M_ROUND: begin
                    check("round_ctl", {o_round_en, o_busy, o_blk_ready, o_acc_en, o_load_blk}, 5'b11000);
                    check("round_idx", o_round_idx, r);
                    check("w_sel", o_w_sel, (r >= MW));
                    r++;
                    if (r == R) ph = M_ACC;
                end
                M_ACC: begin
                    check("acc", {o_acc_en, o_round_en, o_blk_ready, o_valid, o_w_sel}, 5'b10000);
                    check("acc_blk_cnt", o_blk_cnt, cur.num);
                    ph = cur.last ? M_DONE : M_LOAD;
                end
                M_DONE: begin
                    check("done_valid", {o_valid, o_busy, o_blk_ready, o_round_en, o_acc_en}, 5'b11000);
                    if (i_ready) begin
                        if (msg_q.size() == 0) fail_now("unexpected_digest");
                        else check("digest_blk_cnt", o_blk_cnt, msg_q.pop_front());
                        ph = M_IDLE;
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    // One message of nblk blocks; hold0 forces i_blk_valid low for that many
    // LOAD cycles before block 0; rdy_wait delays the digest consumer.
    task automatic send_msg(input int nblk, input int max_gap, input int hold0, input int rdy_wait);
        int k;
        int gap;
        for (int b = 0; b < nblk; b++)
            blk_q.push_back('{first: (b == 0), last: (b == nblk - 1), num: b + 1});
        msg_q.push_back(nblk);
        i_start     = 1'b1;
        i_blk_valid = 1'($urandom_range(0, 1));
        i_last_blk  = 1'($urandom_range(0, 1));
        tick();
        i_start = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            k = 0;
            while (!o_blk_ready && k < R + 10) begin
                i_blk_valid = 1'($urandom_range(0, 1));
                i_last_blk  = 1'($urandom_range(0, 1));
                i_start     = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
            i_start = 1'b0;
            if (!o_blk_ready) fail_now("wait_blk_ready");
            gap = (b == 0 && hold0 > 0) ? hold0 : $urandom_range(0, max_gap);
            i_blk_valid = 1'b0;
            repeat (gap) tick();
            i_blk_valid = 1'b1;
            i_last_blk  = (b == nblk - 1);
            tick();
        end
        k = 0;
        while (!o_valid && k < R + 10) begin
            i_blk_valid = 1'($urandom_range(0, 1));
            i_start     = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        i_start     = 1'b0;
        i_blk_valid = 1'b0;
        if (!o_valid) fail_now("wait_valid");
        repeat (rdy_wait) tick();
        i_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_ready = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic wait_idx(input int target, input string name);
        int k;
        k = 0;
        while (int'(o_round_idx) != target && k < R + 10) begin
            i_start = (int'(o_round_idx) == 5);
            tick();
            k++;
        end
        i_start = 1'b0;
        if (int'(o_round_idx) != target) fail_now(name);
    endtask

    task automatic reset_mid();
        blk_q.push_back('{first: 1'b1, last: 1'b1, num: 1});
        msg_q.push_back(1);
        i_start = 1'b1; i_blk_valid = 1'b1; i_last_blk = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_blk_valid = 1'b0;
        wait_idx(30, "wait_round30");
        #1;
        usr_reset_n = 1'b0;
        #1;
        check("reset_async_ctl", {o_busy, o_blk_ready, o_round_en, o_acc_en, o_valid, o_load_blk, o_init, o_w_sel}, 0);
        check("reset_async_cnt", {o_round_idx, o_blk_cnt}, 0);
        blk_q.delete();
        msg_q.delete();
        tick();
        usr_reset_n = 1'b1;
        repeat (R + 8) tick();
    endtask

`ifdef SHA_CTRL_ABORT_EN
    task automatic abort_mid();
        blk_q.push_back('{first: 1'b1, last: 1'b1, num: 1});
        msg_q.push_back(1);
        i_start = 1'b1; i_blk_valid = 1'b1; i_last_blk = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_blk_valid = 1'b0;
        wait_idx(10, "wait_round10");
        i_abort = 1'b1;
        blk_q.delete();
        msg_q.delete();
        tick();
        i_abort = 1'b0;
        check("abort_idle", {o_busy, o_blk_ready, o_round_en, o_acc_en, o_valid, o_w_sel}, 0);
        check("abort_cnt", {o_round_idx, o_blk_cnt}, 0);
        tick();
        send_msg(1, 0, 0, 0);
    endtask
`endif

    task automatic run80();
        int hs, en_cnt, ws_cnt, max_idx, seq_err, val_at;
        hs = -1; en_cnt = 0; ws_cnt = 0; max_idx = 0; seq_err = 0; val_at = -1;
        s_start = 1'b1;
        s_valid = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 0; c < R80 + 20; c++) begin
            @(negedge usr_clk);
            if (p_load && hs < 0) hs = c;
            if (p_round_en) begin
                if (int'(p_idx) != en_cnt) seq_err++;
                en_cnt++;
                if (p_w_sel) ws_cnt++;
                if (int'(p_idx) > max_idx) max_idx = int'(p_idx);
            end
            if (p_valid && val_at < 0) val_at = c;
        end
        s_valid = 1'b0;
        check("r80_handshake_cycle", hs, 0);
        check("r80_round_cycles", en_cnt, R80);
        check("r80_wsel_cycles", ws_cnt, R80 - MW);
        check("r80_max_idx", max_idx, R80 - 1);
        check("r80_idx_seq_errors", seq_err, 0);
        check("r80_valid_latency", val_at - hs, R80 + 2);
        check("r80_blk_cnt", p_cnt, 1);
        tick();
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        tick();
        check("r80_after_ready", {p_valid, p_busy, p_ready}, 0);
    endtask

    initial begin : stimulus
        #1;
        usr_reset_n = 1'b0;
        #2;
        check("reset_outputs", {o_busy, o_blk_ready, o_round_en, o_acc_en, o_valid, o_load_blk, o_init, o_w_sel}, 0);
        check("reset_counts", {o_round_idx, o_blk_cnt}, 0);
        tick();
        tick();
        usr_reset_n = 1'b1;
        repeat (2) tick();

        send_msg(1, 0, 0, 0);
        send_msg(3, 3, 0, 2);
        send_msg(2, 2, 5, 10);
        for (int i = 0; i < 3; i++)
            send_msg($urandom_range(1, 4), 4, 0, $urandom_range(0, 3));
        reset_mid();
`ifdef SHA_CTRL_ABORT_EN
        abort_mid();
`endif
        run80();

        repeat (4) tick();
        if (blk_q.size() != 0) fail_now("blocks_left_unconsumed");
        if (msg_q.size() != 0) fail_now("digests_left_unconsumed");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sha_round_ctrl.md
# sha_round_ctrl

Parametrised control unit for the SHA hashing core: sequences multi-block messages through a configurable number of compression rounds. It owns its round counter instead of relying on an external counter flag. It drives the message-schedule select, round enable, K-ROM index, and hash accumulate strobes, and exposes valid/ready handshakes on both the block input and the digest output. It sits between the message buffer and the SHA round datapath.

## Interface
- ROUNDS, 64: compression rounds per block (64 for SHA-256, 80 for SHA-1/SHA-512); legal range 2..1024.
- MSG_WORDS, 16: rounds that take W directly from the message block; 1 ≤ MSG_WORDS ≤ ROUNDS.
- BLK_CNT_W, 16: width of the per-message block counter.
- CNT_W, $clog2(ROUNDS): derived; not overridden.
- usr_clk  in  1  system clock, rising edge.
- usr_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  begin a new message; honoured only in IDLE.
- i_blk_valid  in  1  message buffer holds a block.
- i_last_blk  in  1  qualifies i_blk_valid; the block is the final one of the message.
- o_blk_ready  out  1  controller accepts a block.
- o_load_blk  out  1  pulse: load block into schedule registers.
- o_init  out  1  pulse: load H0 initial constants (first block only).
- o_round_en  out  1  advance datapath one round.
- o_round_idx  out  CNT_W  current round, K-ROM address.
- o_w_sel  out  1  0 = message word, 1 = expanded schedule word.
- o_acc_en  out  1  pulse: H += working variables.
- o_blk_cnt  out  BLK_CNT_W  blocks accepted in the current message.
- o_busy  out  1  state ≠ IDLE.
- o_valid  out  1  digest available.
- i_ready  in  1  digest consumer accepts.

## Operation
- States: IDLE, LOAD, ROUND, ACC, DONE (enum in package).
- IDLE: i_start → LOAD; first_blk flag set; o_blk_cnt cleared to 0.
- LOAD: o_blk_ready=1. Block handshake occurs when i_blk_valid=1: o_load_blk=1 and o_init=first_blk in the same cycle (combinational). last flag latched from i_last_blk. o_blk_cnt increments, saturating at all-ones. Round index cleared. Next state is ROUND.
- ROUND: o_round_en=1 each cycle. o_round_idx counts 0..ROUNDS-1. o_w_sel = (o_round_idx ≥ MSG_WORDS). At idx ROUNDS-1 → ACC.
- ACC: o_acc_en=1 for one cycle; first_blk cleared. If last → DONE, else → LOAD.
- DONE: o_valid=1, held until i_ready=1 → IDLE. o_valid does not drop without i_ready.
- i_start outside IDLE is ignored. i_start together with i_ready in DONE is ignored; it must be re-presented in IDLE.
- i_blk_valid outside LOAD is ignored. No block is consumed.
- Outside ROUND: o_round_idx=0, o_w_sel=0.

## Timing
- Reset (asynchronous, immediate): state IDLE; every output 0; o_round_idx=0; o_blk_cnt=0.
- Reset asserted mid-message forces IDLE. No o_acc_en or o_valid is produced for the aborted message.
- Handshake at cycle T → ROUND T+1..T+ROUNDS → ACC T+ROUNDS+1.
- Next LOAD is at T+ROUNDS+2, or o_valid rises at T+ROUNDS+2.
- Per-block throughput: ROUNDS+2 cycles with i_blk_valid held high.
- Start-to-first-handshake: i_start at cycle S → LOAD at S+1, handshake no earlier than S+1.
- All outputs are registered, except o_load_blk and o_init, which are Mealy on i_blk_valid.

## Configuration
- SHA_CTRL_ABORT_EN defined: adds port i_abort (in, 1).
  - i_abort=1 in any state → IDLE next cycle; first_blk, last and counters cleared; o_valid drops.
  - Priority: i_abort over every other input.
- SHA_CTRL_ABORT_EN undefined: port absent; a message can only be cut short by usr_reset_n.

## Structure
- Package sha_ctrl_pkg holds:
  - state enum typedef sha_ctrl_state_t;
  - constants SHA256_ROUNDS=64, SHA1_ROUNDS=80, SHA512_ROUNDS=80, SHA_MSG_WORDS=16.
- Sub-module sha_round_cnt (parameter ROUNDS): clear, enable, index output, terminal flag (idx==ROUNDS-1). The FSM instantiates one.

## Test plan
- Reset then idle: all outputs 0 → i_start with i_blk_valid=1, i_last_blk=1, ROUNDS=64:
  - o_init and o_load_blk pulse together;
  - 64 o_round_en cycles with idx 0..63;
  - o_w_sel rises at idx 16;
  - o_acc_en one cycle; o_valid 66 cycles after handshake.
- 3-block message (i_last_blk only on 3rd): o_init only on block 1; three o_acc_en pulses; o_blk_cnt=3; o_valid once.
- Backpressure: i_blk_valid low 5 cycles in LOAD → o_blk_ready held, no o_round_en. Hold o_valid with i_ready=0 for 10 cycles → o_valid stays 1, state DONE.
- ROUNDS=80, MSG_WORDS=16: idx reaches 79; w_sel=1 for 64 cycles.
- usr_reset_n pulsed at round 30 → all outputs 0 immediately; no o_acc_en. i_start in ROUND ignored.
- With SHA_CTRL_ABORT_EN: i_abort in ROUND idx 10 → IDLE next cycle. A following message with 1 block completes normally, with o_blk_cnt=1.
